// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: FSM state encoding and
// config-port register addresses.
package intc_pkg;

  // Controller phases: waiting for a request, asserting INT, holding one in service.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } intc_state_t;

  // Config port register map.
  localparam logic [1:0] REG_MASK = 2'd0;  // read/write enable per source
  localparam logic [1:0] REG_PEND = 2'd1;  // read, write-1-to-clear
  localparam logic [1:0] REG_ID   = 2'd2;  // read, id of the granted source
  localparam logic [1:0] REG_EOI  = 2'd3;  // write-only end of interrupt

endpackage

// File: rtl/intc_prio_sel.sv
// Combinational priority selector: picks the first set bit of req, scanning
// upward from start and wrapping modulo N_IRQ. With start tied to 0 this is
// plain lowest-index-wins fixed priority.
module intc_prio_sel #(
  parameter int N_IRQ = 8,
  parameter int ID_W  = $clog2(N_IRQ)
) (
  input  logic [N_IRQ-1:0] req,
  input  logic [ID_W-1:0]  start,
  output logic             valid,
  output logic [ID_W-1:0]  id
);

  // Scan offsets from far to near so the nearest set bit after start is the last one written.
  always_comb begin
    int idx;
    valid = |req;
    id    = '0;
    idx   = 0;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= N_IRQ) begin
        idx = idx - N_IRQ;
      end
      if (req[idx]) begin
        id = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller, source side of the CPU interrupt protocol.
// Collects N_IRQ maskable edge-triggered sources plus one NMI, raises INT/NMI
// toward the CPU, uses INA / isInterrupted as acknowledge, and keeps one
// maskable interrupt in service until software writes EOI.
// Build option: define ROUND_ROBIN_EN for rotating priority starting after
// the last granted id; otherwise the lowest pending, unmasked index wins.
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int N_IRQ = 8,
  parameter int ID_W  = $clog2(N_IRQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_src,
  input  logic             nmi_src,
  input  logic             INA,
  input  logic             isInterrupted,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [N_IRQ-1:0] cfg_wdata,
  output logic [N_IRQ-1:0] cfg_rdata,
  output logic             INT,
  output logic             NMI,
  output logic [ID_W-1:0]  irq_id,
  output logic             busy
);

  intc_state_t      state_reg, state_next;
  logic [N_IRQ-1:0] irq_q_reg;
  logic             nmi_q_reg, ina_q_reg, isint_q_reg;
  logic [N_IRQ-1:0] pend_reg, pend_next;
  logic [N_IRQ-1:0] mask_reg;
  logic             nmi_pend_reg, nmi_pend_next;
  logic [ID_W-1:0]  id_reg;

  logic [N_IRQ-1:0] irq_rise;
  logic             nmi_rise, ina_rise, isint_rise;
  logic             mask_wr, pend_wr, eoi_wr;
  logic             grant, take;
  logic [N_IRQ-1:0] id_onehot, w1c_clr, ack_clr;
  logic             sel_valid;
  logic [ID_W-1:0]  sel_id, start_idx;

  // Edge detection against the previous-cycle samples.
  assign irq_rise   = irq_src & ~irq_q_reg;
  assign nmi_rise   = nmi_src & ~nmi_q_reg;
  assign ina_rise   = INA & ~ina_q_reg;
  assign isint_rise = isInterrupted & ~isint_q_reg;

  assign mask_wr = cfg_we && (cfg_addr == REG_MASK);
  assign pend_wr = cfg_we && (cfg_addr == REG_PEND);
  assign eoi_wr  = cfg_we && (cfg_addr == REG_EOI);

  assign grant = (state_reg == IDLE) && sel_valid;
  assign take  = (state_reg == REQ) && ina_rise;

  // The source currently asserting INT is protected from software clears
  // until the CPU takes it; the ack clear hits only that source.
  assign id_onehot = N_IRQ'(1) << id_reg;
  assign w1c_clr   = pend_wr ? (cfg_wdata & ~((state_reg == REQ) ? id_onehot : '0)) : '0;
  assign ack_clr   = take ? id_onehot : '0;
  // A new edge in the same cycle as a clear keeps the bit set.
  assign pend_next = (pend_reg & ~(w1c_clr | ack_clr)) | irq_rise;

  // NMI clears only on an isInterrupted rise that is not a maskable take.
  assign nmi_pend_next = (nmi_pend_reg & ~(isint_rise & ~INA)) | nmi_rise;

  intc_prio_sel #(
    .N_IRQ (N_IRQ),
    .ID_W  (ID_W)
  ) u_prio_sel (
    .req   (pend_reg & mask_reg),
    .start (start_idx),
    .valid (sel_valid),
    .id    (sel_id)
  );

`ifdef ROUND_ROBIN_EN
  logic [ID_W-1:0] last_reg;

  // Remember the last grant so the next search starts just past it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_reg <= ID_W'(N_IRQ - 1);
    end else if (grant) begin
      last_reg <= sel_id;
    end
  end

  assign start_idx = (last_reg == ID_W'(N_IRQ - 1)) ? '0 : last_reg + ID_W'(1);
`else
  assign start_idx = '0;
`endif

  // Input history, pending/mask registers, NMI flag and the latched id.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q_reg    <= '0;
      nmi_q_reg    <= 1'b0;
      ina_q_reg    <= 1'b0;
      isint_q_reg  <= 1'b0;
      pend_reg     <= '0;
      mask_reg     <= '0;
      nmi_pend_reg <= 1'b0;
      id_reg       <= '0;
    end else begin
      irq_q_reg    <= irq_src;
      nmi_q_reg    <= nmi_src;
      ina_q_reg    <= INA;
      isint_q_reg  <= isInterrupted;
      pend_reg     <= pend_next;
      nmi_pend_reg <= nmi_pend_next;
      if (mask_wr) begin
        mask_reg <= cfg_wdata;
      end
      if (grant) begin
        id_reg <= sel_id;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state: grant, CPU take, EOI. EOI outside SERVICE is ignored.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (sel_valid) state_next = REQ;
      REQ:     if (ina_rise)  state_next = SERVICE;
      SERVICE: if (eoi_wr)    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign INT    = (state_reg == REQ);
  assign busy   = (state_reg == SERVICE);
  assign NMI    = nmi_pend_reg;
  assign irq_id = id_reg;

  // Config read mux; EOI is write-only and reads as zero.
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      REG_MASK: cfg_rdata = mask_reg;
      REG_PEND: cfg_rdata = pend_reg;
      REG_ID:   cfg_rdata = N_IRQ'(id_reg);
      default:  cfg_rdata = '0;
    endcase
  end

endmodule
